// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, mult/div handshake.
// Optional HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int RW         = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [RW-1:0] ifid_rs,
    input  logic [RW-1:0] ifid_rt,
    input  logic          ifid_uses_rt,
    input  logic          idex_memread,
    input  logic [RW-1:0] idex_rt,
    input  logic          branch_taken,
    input  logic          md_start,
    input  logic          md_done,
    output logic          hazard_hold,
    output logic          pc_write,
    output logic          idex_bubble,
    output logic          ifid_flush,
    output logic          md_go,
    output logic          md_error
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [15:0]   flush_cycles
`endif
);

    localparam int CW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MD_TIMEOUT - 1);

    typedef enum logic {
        RUN,
        MD_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          lu;
    logic          expired;

    assign lu = idex_memread && (idex_rt != '0) &&
                ((idex_rt == ifid_rs) ||
                 (ifid_uses_rt && (idex_rt == ifid_rt)));

    // md_done wins over a coincident timeout: no error in that case
    assign expired = (state == MD_WAIT) && (cnt == LAST) && !md_done;

    always_comb begin
        state_nxt   = state;
        hazard_hold = 1'b0;
        pc_write    = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        md_go       = 1'b0;
        if (!reset_n) begin
            state_nxt   = RUN;
            hazard_hold = 1'b1;
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (lu) begin
                        hazard_hold = 1'b1;
                        pc_write    = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (md_start) begin
                        md_go       = 1'b1;
                        hazard_hold = 1'b1;
                        pc_write    = 1'b0;
                        idex_bubble = 1'b1;
                        state_nxt   = MD_WAIT;
                    end else if (branch_taken) begin
                        ifid_flush  = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_done || expired) begin
                        state_nxt   = RUN;
                    end else begin
                        hazard_hold = 1'b1;
                        pc_write    = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RUN;
            cnt      <= '0;
            md_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (md_go) begin
                cnt <= '0;
            end else if (state == MD_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (expired) begin
                md_error <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (hazard_hold && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (ifid_flush && !(&flush_cycles)) begin
                flush_cycles <= flush_cycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// checked every cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [4:0] ifid_rs, ifid_rt, idex_rt;
    logic       ifid_uses_rt, idex_memread, branch_taken;
    logic       md_start, md_done;
    logic       hazard_hold, pc_write, idex_bubble;
    logic       ifid_flush, md_go, md_error;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_wait = 0;
    int m_waited = 0;
    bit m_err = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    pipe_hazard_ctrl #(.MD_TIMEOUT(TO), .RW(5)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .ifid_rs     (ifid_rs),
        .ifid_rt     (ifid_rt),
        .ifid_uses_rt(ifid_uses_rt),
        .idex_memread(idex_memread),
        .idex_rt     (idex_rt),
        .branch_taken(branch_taken),
        .md_start    (md_start),
        .md_done     (md_done),
        .hazard_hold (hazard_hold),
        .pc_write    (pc_write),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .md_go       (md_go),
        .md_error    (md_error)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [47:0] obs,
                         input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cyc(input string tag, input logic rn,
                       input logic mr, input logic [4:0] lrt,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic br,
                       input logic ms, input logic md);
        bit lu, e_hold, e_pc, e_bub, e_fl, e_go, rel;
        reset_n = rn; idex_memread = mr; idex_rt = lrt;
        ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = urt;
        branch_taken = br; md_start = ms; md_done = md;
        #2;
        if (!rn) begin
            m_wait = 0; m_waited = 0; m_err = 0;
            m_stall = 0; m_flush = 0;
        end
        lu = mr && lrt != 0 && (lrt == rs || (urt && lrt == rt));
        e_hold = 0; e_pc = 1; e_bub = 0; e_fl = 0; e_go = 0; rel = 0;
        if (!rn) begin
            e_hold = 1; e_pc = 0; e_bub = 1;
        end else if (!m_wait) begin
            if (lu) begin
                e_hold = 1; e_pc = 0; e_bub = 1;
            end else if (ms) begin
                e_go = 1; e_hold = 1; e_pc = 0; e_bub = 1;
            end else if (br) begin
                e_fl = 1;
            end
        end else begin
            rel = md || (m_waited == TO - 1);
            if (!rel) begin
                e_hold = 1; e_pc = 0; e_bub = 1;
            end
        end
        check(tag,
              48'({hazard_hold, pc_write, idex_bubble,
                   ifid_flush, md_go, md_error}),
              48'({e_hold, e_pc, e_bub, e_fl, e_go, m_err}));
`ifdef HAZARD_STATS_EN
        check({tag, "_stats"}, {stall_cycles, flush_cycles},
              {m_stall[31:0], m_flush[15:0]});
`endif
        if (rn) begin
            if (e_hold && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_fl && m_flush < 64'hFFFF) m_flush++;
            if (!m_wait) begin
                if (e_go) begin
                    m_wait = 1; m_waited = 0;
                end
            end else if (rel) begin
                m_wait = 0;
                if (!md) m_err = 1;
            end else begin
                m_waited++;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input string tag, input logic ms, input logic md);
        cyc(tag, 1, 0, 0, 0, 0, 0, 0, ms, md);
    endtask

    initial begin
        ifid_rs = 0; ifid_rt = 0; idex_rt = 0; ifid_uses_rt = 0;
        idex_memread = 0; branch_taken = 0; md_start = 0; md_done = 0;

        // reset with md_start asserted
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle("run0", 0, 0);

        // load-use and its non-hazard variants
        cyc("lu_rs", 1, 1, 8, 8, 0, 0, 0, 0, 0);
        cyc("lu_gone", 1, 0, 8, 8, 0, 0, 0, 0, 0);
        cyc("lu_r0", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("lu_nort", 1, 1, 8, 3, 8, 0, 0, 0, 0);
        cyc("lu_rt", 1, 1, 8, 3, 8, 1, 0, 0, 0);

        // branch masked by load-use, then taken
        cyc("br_lu", 1, 1, 9, 9, 0, 0, 1, 0, 0);
        cyc("br_go", 1, 0, 9, 9, 0, 0, 1, 0, 0);

        // mult/div with done 5 cycles after go; md_start ignored meanwhile
        idle("md_go", 1, 0);
        for (int i = 1; i < 5; i++) idle("md_wait", 1, 0);
        idle("md_done", 1, 1);
        idle("md_after", 0, 0);
        idle("md_late", 0, 1);

        // timeout, then sticky error
        idle("to_go", 1, 0);
        for (int i = 0; i < TO; i++) idle("to_wait", 0, 0);
        for (int i = 0; i < 3; i++) cyc("to_sticky", 1, 0, 0, 0, 0, 0, 1, 0, 0);

        // reset mid-wait, late done ignored
        idle("rw_go", 1, 0);
        idle("rw_wait", 0, 0);
        cyc("rw_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle("rw_late", 0, 1);
        idle("rw_run", 0, 0);

        // three load-use stalls and two flushes from a fresh reset
        cyc("st_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc("st_lu", 1, 1, 5, 5, 0, 0, 0, 0, 0);
            idle("st_gap", 0, 0);
        end
        for (int i = 0; i < 2; i++) cyc("st_br", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle("st_end", 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(0, 49) != 0),
                $urandom_range(0, 1),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)),
                $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 11) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
